// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths, load_op encodings and FSM states shared by the memory stage
package mem_stage_pkg;
  localparam int ES_TO_MS_BUS_WD = 105;
  localparam int MS_TO_WS_BUS_WD = 102;
  localparam int MS_TO_ES_BUS_WD = 38;
  localparam logic [2:0] LOAD_NONE = 3'd0;
  localparam logic [2:0] LOAD_B    = 3'd1;
  localparam logic [2:0] LOAD_H    = 3'd2;
  localparam logic [2:0] LOAD_W    = 3'd3;
  localparam logic [2:0] LOAD_BU   = 3'd4;
  localparam logic [2:0] LOAD_HU   = 3'd5;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} ms_state_e;
  function automatic logic is_load(input logic [2:0] op);
    return op inside {LOAD_B, LOAD_H, LOAD_W, LOAD_BU, LOAD_HU};
  endfunction
endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: selects the addressed byte/half lane of a load word and sign/zero-extends it
module load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  load_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result
);
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  assign byte_lane = rdata[{addr, 3'b000} +: 8];
  assign half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
  // extend the selected lane according to the load kind; words pass through
  always_comb begin
    result = load_op == LOAD_B  ? {{24{byte_lane[7]}}, byte_lane} :
             load_op == LOAD_H  ? {{16{half_lane[15]}}, half_lane} :
             load_op == LOAD_BU ? {24'd0, byte_lane} :
             load_op == LOAD_HU ? {16'd0, half_lane} : rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage; load counters are built when MS_LOAD_PERF_CNT_EN is defined
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [5:0]                 stall,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_ES_BUS_WD-1:0] ms_to_es_bus,
  output logic                       ms_stallreq
`ifdef MS_LOAD_PERF_CNT_EN
  ,
  output logic [31:0]                perf_load_cnt,
  output logic [31:0]                perf_wait_cnt
`endif
);
  logic [ES_TO_MS_BUS_WD-1:0] bus_q, bus_d;
  ms_state_e   state_q, state_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;
  logic [2:0]  load_op;
  logic        reg_we;
  logic [4:0]  dest;
  logic [31:0] alu_result, pc, inst;
  logic        has_load, busy, accept, pending, out_we;
  logic [31:0] aligned, final_result;
  logic        unused;
  assign {load_op, reg_we, dest, alu_result, pc, inst} = bus_q;
  assign has_load = is_load(load_op);
  assign busy     = (state_q == IDLE && has_load) || state_q == WAIT;
  assign accept   = busy && data_sram_data_ok;
  assign pending  = busy && !data_sram_data_ok;
  assign out_we   = reg_we && !pending;
  assign ms_stallreq = pending;
  load_align u_load_align (
    .load_op(load_op),
    .addr   (alu_result[1:0]),
    .rdata  (accept ? data_sram_rdata : rdata_buf_q),
    .result (aligned)
  );
  assign final_result = has_load ? aligned : alu_result;
  assign ms_to_ws_bus = {out_we, dest, final_result, pc, inst};
  assign ms_to_es_bus = {out_we, dest, final_result};
  assign unused = ^{stall[5], stall[2:0]};
  // stage register update, load handshake FSM and response buffer; a response accepted while held parks in DONE
  always_comb begin
    bus_d = (reset || flush || (stall[3] && !stall[4])) ? '0 : !stall[3] ? es_to_ms_bus : bus_q;
    state_d = (reset || flush) ? IDLE :
              accept ? (stall[3] ? DONE : IDLE) :
              pending ? WAIT :
              (state_q == DONE && !stall[3]) ? IDLE : state_q;
    rdata_buf_d = reset ? '0 : accept ? data_sram_rdata : rdata_buf_q;
  end
  // state registers
  always_ff @(posedge clk) begin
    bus_q       <= bus_d;
    state_q     <= state_d;
    rdata_buf_q <= rdata_buf_d;
  end
`ifdef MS_LOAD_PERF_CNT_EN
  logic [31:0] perf_load_cnt_q, perf_load_cnt_d, perf_wait_cnt_q, perf_wait_cnt_d;
  // completed loads and WAIT cycles; only reset clears them, a flushed response does not count
  always_comb begin
    perf_load_cnt_d = reset ? '0 : perf_load_cnt_q + {31'd0, accept && !flush};
    perf_wait_cnt_d = reset ? '0 : perf_wait_cnt_q + {31'd0, state_q == WAIT};
  end
  // counter registers
  always_ff @(posedge clk) begin
    perf_load_cnt_q <= perf_load_cnt_d;
    perf_wait_cnt_q <= perf_wait_cnt_d;
  end
  assign perf_load_cnt = perf_load_cnt_q;
  assign perf_wait_cnt = perf_wait_cnt_q;
`endif
endmodule
